// File: rtl/accum_sequencer.sv
// accum_sequencer: drives an external accumulator through a clear/load/add job,
// then reads back sum bytes, add counter and counter carry through a muxed port.
// The sequencer itself performs no arithmetic; it only sequences and captures.
//
// Operand handshake: op_data is transferred on a rising clock edge where
// op_valid=1 and op_ready=1. op_ready is high only in FETCH and does not depend
// on op_valid. The producer may hold op_valid and op_data for any number of
// cycles; the sequencer waits in FETCH as long as needed.
module accum_sequencer #(
  parameter logic [2:0]  SEL_LSB   = 3'd0,
  parameter logic [2:0]  SEL_MSB   = 3'd1,
  parameter logic [2:0]  SEL_CNT   = 3'd2,
  parameter logic [2:0]  SEL_CARRY = 3'd3,
  parameter int unsigned READ_LAT  = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  op_count,
  input  logic [7:0]  op_data,
  input  logic        op_valid,
  output logic        op_ready,
  output logic        acc_reset,
  output logic        acc_load,
  output logic        acc_add,
  output logic [7:0]  acc_data,
  output logic [2:0]  acc_sel,
  input  logic [7:0]  acc_rdata,
  output logic        busy,
  output logic        done,
  output logic [15:0] sum,
  output logic [7:0]  add_count,
  output logic        count_carry,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    FETCH = 3'd2,
    LOAD  = 3'd3,
    ADD   = 3'd4,
    READ  = 3'd5,
    DONE  = 3'd6
  } state_t;

  // Last settle-counter value of a READ step; the capture happens on it.
  localparam logic [2:0] LAT_LAST = 3'(READ_LAT);

  state_t      state_q, state_d;
  logic [7:0]  remaining_q;
  logic [7:0]  acc_data_q;
  logic [2:0]  lat_q;
  logic [1:0]  step_q;
  logic [15:0] sum_q;
  logic [7:0]  add_count_q;
  logic        carry_q;
  logic        read_last;

  assign read_last = (state_q == READ) && (lat_q == LAT_LAST);

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; remaining is already known non-zero in FETCH/LOAD/ADD.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CLEAR;
      CLEAR:   state_d = (remaining_q != 8'd0) ? FETCH : READ;
      FETCH:   if (op_valid) state_d = LOAD;
      LOAD:    state_d = ADD;
      ADD:     state_d = (remaining_q != 8'd1) ? FETCH : READ;
      READ:    if (read_last && (step_q == 2'd3)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Job datapath: operand counter, operand register, read stepping and captures.
  always_ff @(posedge clock) begin
    if (reset) begin
      remaining_q <= 8'd0;
      acc_data_q  <= 8'd0;
      lat_q       <= 3'd0;
      step_q      <= 2'd0;
      sum_q       <= 16'd0;
      add_count_q <= 8'd0;
      carry_q     <= 1'b0;
    end else begin
      if ((state_q == IDLE) && start) remaining_q <= op_count;
      if (state_q == ADD) remaining_q <= remaining_q - 8'd1;
      if ((state_q == FETCH) && op_valid) acc_data_q <= op_data;
      if (state_q == READ) begin
        if (read_last) begin
          lat_q  <= 3'd0;
          step_q <= step_q + 2'd1;
          case (step_q)
            2'd0: sum_q[7:0]  <= acc_rdata;
            2'd1: sum_q[15:8] <= acc_rdata;
            2'd2: add_count_q <= acc_rdata;
            2'd3: carry_q     <= acc_rdata[0];
            default: ;
          endcase
        end else begin
          lat_q <= lat_q + 3'd1;
        end
      end else begin
        lat_q  <= 3'd0;
        step_q <= 2'd0;
      end
    end
  end

  // Outputs decoded from state; reset clears the accumulator in the same cycle.
  always_comb begin
    op_ready  = (state_q == FETCH);
    acc_reset = reset || (state_q == CLEAR);
    acc_load  = (state_q == LOAD);
    acc_add   = (state_q == ADD);
    busy      = (state_q != IDLE);
    done      = (state_q == DONE);
    acc_sel   = SEL_LSB;
    if (state_q == READ) begin
      case (step_q)
        2'd0:    acc_sel = SEL_LSB;
        2'd1:    acc_sel = SEL_MSB;
        2'd2:    acc_sel = SEL_CNT;
        default: acc_sel = SEL_CARRY;
      endcase
    end
  end

  assign acc_data    = acc_data_q;
  assign sum         = sum_q;
  assign add_count   = add_count_q;
  assign count_carry = carry_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_accum_sequencer.sv
// Bench for accum_sequencer: behavioural accumulator on the acc_* port,
// directed jobs with hand-computed sums and latencies, pulse counters, summary.
module tb_accum_sequencer;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset, start, op_valid;
  logic [7:0]  op_count, op_data, acc_rdata;
  logic        op_ready, acc_reset, acc_load, acc_add, busy, done, count_carry;
  logic [7:0]  acc_data, add_count;
  logic [2:0]  acc_sel, state_dbg;
  logic [15:0] sum;

  accum_sequencer dut (
    .clock(clock), .reset(reset), .start(start), .op_count(op_count),
    .op_data(op_data), .op_valid(op_valid), .op_ready(op_ready),
    .acc_reset(acc_reset), .acc_load(acc_load), .acc_add(acc_add),
    .acc_data(acc_data), .acc_sel(acc_sel), .acc_rdata(acc_rdata),
    .busy(busy), .done(done), .sum(sum), .add_count(add_count),
    .count_carry(count_carry), .state_dbg(state_dbg)
  );

  // ---------------- accumulator model ----------------
  // load latches data_in; add sums it and bumps a 9-bit counter (bit 8 = carry).
  logic [15:0] m_sum;
  logic [8:0]  m_cnt;
  logic [7:0]  m_op;

  always @(posedge clock) begin
    if (acc_reset) begin
      m_sum <= 16'd0;
      m_cnt <= 9'd0;
      m_op  <= 8'd0;
    end else begin
      if (acc_load) m_op <= acc_data;
      if (acc_add) begin
        m_sum <= m_sum + {8'd0, m_op};
        m_cnt <= m_cnt + 9'd1;
      end
    end
  end

  always_comb begin
    acc_rdata = 8'd0;
    case (acc_sel)
      3'd0:    acc_rdata = m_sum[7:0];
      3'd1:    acc_rdata = m_sum[15:8];
      3'd2:    acc_rdata = m_cnt[7:0];
      3'd3:    acc_rdata = {7'd0, m_cnt[8]};
      default: acc_rdata = 8'd0;
    endcase
  end

  // ---------------- scoreboard ----------------
  logic [15:0] exp_q[$];
  logic [7:0]  ops [0:255];
  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0, load_cnt = 0, add_cnt = 0, clear_cnt = 0;
  int overlap_cnt = 0, sel_bad_cnt = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance to the next falling edge and tally output pulses seen in that cycle.
  task automatic tick();
    @(negedge clock);
    if (done) done_cnt++;
    if (acc_load) load_cnt++;
    if (acc_add) add_cnt++;
    if (acc_reset && !reset) clear_cnt++;
    if (acc_load && acc_add) overlap_cnt++;
    if (!busy && (acc_sel != 3'd0)) sel_bad_cnt++;
  endtask

  // Run one job from IDLE (called at a falling edge). ops[] holds the operands,
  // gap = FETCH cycles with op_valid low before each operand, spam = keep start high.
  task automatic run_job(input string name, input int n, input int gap, input bit spam,
                         input int exp_lat, input logic [15:0] exp_sum,
                         input logic [7:0] exp_cnt, input logic exp_carry);
    int t, idx, waitc, d0, c0, l0, a0;
    bit seen, pend;
    logic [15:0] e;
    exp_q.push_back(exp_sum);
    d0 = done_cnt; c0 = clear_cnt; l0 = load_cnt; a0 = add_cnt;
    start = 1'b1; op_count = n[7:0]; op_valid = 1'b0;
    t = 0; idx = 0; waitc = 0; seen = 1'b0; pend = 1'b0;
    while (!seen && t < 3000) begin
      tick();
      t++;
      start    = spam;
      op_count = ~n[7:0];
      if (pend) begin idx++; waitc = 0; pend = 1'b0; end
      if (done) begin
        seen = 1'b1;
        e = exp_q.pop_front();
        check({name, "_latency"}, t, exp_lat);
        check({name, "_sum"}, {16'd0, sum}, {16'd0, e});
        check({name, "_add_count"}, {24'd0, add_count}, {24'd0, exp_cnt});
        check({name, "_carry"}, {31'd0, count_carry}, {31'd0, exp_carry});
      end else if (op_ready) begin
        if (waitc < gap) begin
          op_valid = 1'b0;
          waitc++;
        end else begin
          op_valid = 1'b1;
          op_data  = ops[idx];
          pend     = 1'b1;
        end
      end else begin
        op_valid = 1'b0;
      end
    end
    if (!seen) begin
      check({name, "_done_timeout"}, 32'd0, 32'd1);
      void'(exp_q.pop_front());
    end
    tick();
    start = 1'b0;
    check({name, "_idle_after_done"}, {31'd0, busy}, 32'd0);
    check({name, "_done_pulses"}, done_cnt - d0, 32'd1);
    check({name, "_clear_pulses"}, clear_cnt - c0, 32'd1);
    check({name, "_loads"}, load_cnt - l0, n);
    check({name, "_adds"}, add_cnt - a0, n);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int k, a0, d0;
    reset = 1'b1; start = 1'b0; op_valid = 1'b0; op_count = 8'd0; op_data = 8'd0;
    repeat (3) tick();
    #1;
    check("reset_acc_reset", {31'd0, acc_reset}, 32'd1);
    reset = 1'b0;
    tick();
    check("rst_op_ready", {31'd0, op_ready}, 32'd0);
    check("rst_acc_load", {31'd0, acc_load}, 32'd0);
    check("rst_acc_add", {31'd0, acc_add}, 32'd0);
    check("rst_acc_data", {24'd0, acc_data}, 32'd0);
    check("rst_acc_sel", {29'd0, acc_sel}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_sum", {16'd0, sum}, 32'd0);
    check("rst_add_count", {24'd0, add_count}, 32'd0);
    check("rst_carry", {31'd0, count_carry}, 32'd0);
    check("idle_acc_reset", {31'd0, acc_reset}, 32'd0);

    // three operands, valid held high
    ops[0] = 8'd10; ops[1] = 8'd20; ops[2] = 8'd30;
    run_job("three_ops", 3, 0, 1'b0, 19, 16'd60, 8'd3, 1'b0);

    // empty job
    run_job("zero_ops", 0, 0, 1'b0, 10, 16'd0, 8'd0, 1'b0);

    // two operands with five idle FETCH cycles before each
    ops[0] = 8'd100; ops[1] = 8'd200;
    run_job("gapped", 2, 5, 1'b0, 26, 16'd300, 8'd2, 1'b0);

    // maximum job: 255 x 0xFF
    for (int i = 0; i < 256; i++) ops[i] = 8'hFF;
    run_job("max_job", 255, 0, 1'b0, 775, 16'hFE01, 8'd255, 1'b0);

    // start held high throughout the job and into DONE
    ops[0] = 8'd1; ops[1] = 8'd2; ops[2] = 8'd3;
    run_job("start_spam", 3, 0, 1'b1, 19, 16'd6, 8'd3, 1'b0);

    // reset in the second FETCH of a four-operand job
    a0 = add_cnt;
    start = 1'b1; op_count = 8'd4; op_valid = 1'b1; op_data = 8'd5;
    tick();
    start = 1'b0;
    k = 0;
    while (!(op_ready && (add_cnt - a0 == 1)) && k < 50) begin
      tick();
      k++;
    end
    check("abort_reached_fetch2", {31'd0, op_ready}, 32'd1);
    reset = 1'b1;
    #1;
    check("abort_acc_reset", {31'd0, acc_reset}, 32'd1);
    tick();
    reset = 1'b0; op_valid = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_sum", {16'd0, sum}, 32'd0);
    check("abort_add_count", {24'd0, add_count}, 32'd0);
    d0 = done_cnt;
    repeat (12) tick();
    check("abort_no_done", done_cnt - d0, 32'd0);
    ops[0] = 8'd7;
    run_job("after_abort", 1, 0, 1'b0, 13, 16'd7, 8'd1, 1'b0);

    check("load_add_overlap", overlap_cnt, 32'd0);
    check("acc_sel_outside_read", sel_bad_cnt, 32'd0);

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/accum_sequencer.md
ACCUM_SEQUENCER -- requirements
Module: accum_sequencer

Interface
REQ-001 Parameter SEL_LSB, default 3'd0, accumulator output_sel code for sum bits [7:0].
REQ-002 Parameter SEL_MSB, default 3'd1, output_sel code for sum bits [15:8].
REQ-003 Parameter SEL_CNT, default 3'd2, output_sel code for the add-counter value.
REQ-004 Parameter SEL_CARRY, default 3'd3, output_sel code for the counter carry, which appears on bit 0.
REQ-005 Parameter READ_LAT, default 1, range 1-7, settle cycles between an acc_sel change and capture.
REQ-006 One clock; reset is synchronous and active-high.
REQ-007 clock  in  1  rising-edge clock.
REQ-008 reset  in  1  synchronous, active-high reset.
REQ-009 start  in  1  request to begin a job; sampled only in IDLE.
REQ-010 op_count  in  8  number of operands in the job, 0-255.
REQ-011 op_data  in  8  operand value.
REQ-012 op_valid  in  1  op_data is valid.
REQ-013 op_ready  out  1  sequencer accepts op_data this cycle.
REQ-014 acc_reset  out  1  drives accumulator reset.
REQ-015 acc_load  out  1  drives accumulator load.
REQ-016 acc_add  out  1  drives accumulator add.
REQ-017 acc_data  out  8  drives accumulator data_in.
REQ-018 acc_sel  out  3  drives accumulator output_sel.
REQ-019 acc_rdata  in  8  accumulator data_out.
REQ-020 busy  out  1  high in every state except IDLE.
REQ-021 done  out  1  one-cycle pulse when results are valid.
REQ-022 sum  out  16  captured accumulator sum.
REQ-023 add_count  out  8  captured counter value.
REQ-024 count_carry  out  1  captured counter carry.

Function
REQ-025 The FSM SHALL have states IDLE, CLEAR, FETCH, LOAD, ADD, READ, DONE.
REQ-026 In IDLE, when start=1, the FSM SHALL latch op_count into remaining and go to CLEAR.
REQ-027 CLEAR SHALL last 1 cycle with acc_reset=1, then go to FETCH if remaining>0, else to READ.
REQ-028 FETCH SHALL drive op_ready=1; when op_valid=1 it SHALL latch op_data into acc_data and go to LOAD; otherwise it SHALL hold indefinitely.
REQ-029 op_ready SHALL be 0 in every state other than FETCH; a transfer occurs only when op_valid=1 and op_ready=1 in the same cycle.
REQ-030 LOAD SHALL last 1 cycle with acc_load=1 and acc_data held, then go to ADD.
REQ-031 ADD SHALL last 1 cycle with acc_add=1 and decrement remaining; it SHALL then go to FETCH if the decremented remaining is >0, else to READ.
REQ-032 Each operand SHALL cost exactly 3 cycles when op_valid is held high (FETCH, LOAD, ADD).
REQ-033 READ SHALL step acc_sel through SEL_LSB, SEL_MSB, SEL_CNT, SEL_CARRY in that order.
REQ-034 Each READ step SHALL hold acc_sel for READ_LAT+1 cycles and capture acc_rdata on the last cycle of the step.
REQ-035 READ captures SHALL go to sum[7:0], sum[15:8], add_count, and count_carry (=acc_rdata[0]) in step order.
REQ-036 After the fourth capture the FSM SHALL go to DONE, pulse done=1 for 1 cycle, then return to IDLE.
REQ-037 sum, add_count and count_carry SHALL update only in READ and SHALL be stable from the done pulse until the next job's READ.
REQ-038 For op_count=0 and READ_LAT=1, start-to-done latency SHALL be 10 cycles (1 CLEAR + 8 READ + 1 DONE).
REQ-039 With op_valid held high, start-to-done latency SHALL be 10+3*op_count cycles.
REQ-040 start SHALL be ignored when busy=1, and start asserted in the DONE cycle SHALL also be ignored.
REQ-041 op_count SHALL be sampled only at start; later changes SHALL NOT affect the running job.
REQ-042 The sequencer SHALL perform no arithmetic; sum SHALL equal the accumulator value captured, including 16-bit wrap.
REQ-043 acc_load and acc_add SHALL never be asserted in the same cycle.
REQ-044 acc_sel SHALL be SEL_LSB outside READ.

Reset
REQ-045 While reset=1 at a clock edge, the FSM SHALL go to IDLE and remaining SHALL clear to 0.
REQ-046 While reset=1, acc_reset SHALL be driven 1 combinationally so that the accumulator is cleared in the same cycle.
REQ-047 On reset the outputs SHALL take these values: op_ready=0, acc_load=0, acc_add=0, acc_data=0, acc_sel=SEL_LSB, busy=0, done=0, sum=0, add_count=0, count_carry=0.
REQ-048 Reset asserted mid-job SHALL abort the job with no done pulse; a new start after reset SHALL behave as from power-up.

Verification
REQ-049 op_count=3, operands 10,20,30, op_valid held high -> done at cycle 19, sum=60, add_count=3, count_carry=0.
REQ-050 op_count=0 -> done at cycle 10, no acc_load/acc_add pulses, sum=0, add_count=0.
REQ-051 op_count=2, op_valid low for 5 cycles before each operand -> done delayed by 10 cycles, sum equals the operand total.
REQ-052 op_count=255, all operands 0xFF -> sum=0xFE01, add_count=255, count_carry per accumulator model.
REQ-053 reset pulsed in the second FETCH of a 4-operand job -> busy=0 the next cycle, no done pulse; a following 1-operand job of 7 -> sum=7, add_count=1.
REQ-054 start re-asserted every cycle during a job -> exactly one done pulse per accepted start, and no extra CLEAR pulse.
